nios2_debug_cmd_sync: RTL and testbench
=======================================

Name: nios2_debug_cmd_sync

Overview:
- System-clock half of the Nios II JTAG debug slave, parametrised successor of the fixed 38-bit/2-bit-IR sysclk decoder.
- Takes the TCK-domain shift register, IR and update strobes, and synchronises the strobes into clk.
- Captures each completed DR scan as a command and decodes one-hot action / no-action pulses per IR value.
- New over the previous generation: valid/ready command handshake with overrun detection, and parametrised widths and synchroniser depth.

Parameters:
DATA_W, 38, width of the scanned data register and jdo
IR_W, 2, width of the virtual-JTAG instruction register; 2**IR_W decoded channels
SYNC_STAGES, 2, flops in each strobe synchroniser (legal range 2..4)
ACT_BIT, 34, index into the captured data selecting action (1) vs no-action (0)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
sr  in  DATA_W  TCK-domain scan data; quasi-static while vs_udr is high
ir_in  in  IR_W  TCK-domain IR value; quasi-static while vs_uir/vs_udr are high
vs_uir  in  1  TCK-domain update-IR level, asynchronous to clk
vs_udr  in  1  TCK-domain update-DR level, asynchronous to clk
jdo  out  DATA_W  last captured scan data
cmd_valid  out  1  a captured command is pending
cmd_ir  out  IR_W  IR value associated with the pending command
cmd_ready  in  1  consumer accepts the command when high together with cmd_valid
take_action  out  2**IR_W  one-cycle pulse on bit cmd_ir when the captured data has ACT_BIT=1
take_no_action  out  2**IR_W  one-cycle pulse on bit cmd_ir when the captured data has ACT_BIT=0
ir_update  out  1  one-cycle pulse when a new IR is latched
overrun  out  1  sticky: a command was overwritten before it was accepted
overrun_clr  in  1  clears overrun

Behaviour:
- Reset (async assert, sync release): every output is 0, including jdo, cmd_ir and both pulse vectors; synchroniser and edge flops are 0.
- Strobe synchronisation: vs_udr and vs_uir each pass through a SYNC_STAGES flop chain, then a previous-value flop.
- Edge detection: udr_edge = sync_out & ~prev, and likewise uir_edge. There is no action on falling edges.
- sr and ir_in are sampled directly, without synchronisation, only in the cycle of the corresponding edge.
- On uir_edge:
  - ir_q <= ir_in.
  - ir_update pulses for 1 cycle, registered, so it appears the cycle after the edge.
- On udr_edge, all updates are registered and appear together on the next clk edge:
  - jdo <= sr.
  - cmd_ir <= ir_in if uir_edge occurs in the same cycle, else ir_q.
  - cmd_valid <= 1.
  - If sr[ACT_BIT]=1, take_action[ir] pulses; otherwise take_no_action[ir] pulses. Exactly one bit across both vectors is high, for exactly 1 cycle.
- Latency: vs_udr rising edge to jdo/pulse visible = SYNC_STAGES+1 clk edges after the first clk edge that samples vs_udr high, i.e. 3 edges at the default.
- Handshake:
  - cmd_valid clears on the edge where cmd_valid & cmd_ready; jdo and cmd_ir hold their values after acceptance.
  - udr_edge while cmd_valid & ~cmd_ready: the new command overwrites the old one (latest wins), cmd_valid stays 1, overrun <= 1.
  - udr_edge in the same cycle as an accept: the old command is consumed, the new one loads, cmd_valid stays 1, overrun is unchanged.
  - cmd_ready while cmd_valid=0: ignored.
- overrun:
  - Stays set until an overrun_clr cycle.
  - If a set condition and overrun_clr occur in the same cycle, set wins.
- vs_udr held high for many cycles produces exactly one command.
- Reset mid-operation: a pending command and all in-flight synchroniser state are discarded. A vs_udr still high when reset releases is seen as a rising edge and captured as a fresh command.

Test Plan:
- Reset asserted while vs_udr=1 and a command is pending -> all outputs 0 during reset; after release, one capture occurs SYNC_STAGES+1 cycles later with cmd_valid=1.
- IR scan with ir_in=2'b01, vs_uir pulse -> ir_update 1-cycle pulse at cycle 3. Then DR scan with sr=38'h04_0000_1234 (bit34=1) and vs_udr high for 10 clk -> jdo=38'h04_0000_1234, cmd_ir=1, take_action=4'b0010 for exactly 1 cycle, take_no_action=0, cmd_valid=1.
- Same flow with ir_in=2'b11 and sr=38'h00_0000_00FF (bit34=0) -> take_no_action=4'b1000 for 1 cycle; cmd_ready=1 one cycle later -> cmd_valid falls on the next edge.
- Two DR scans (sr=38'h11, then sr=38'h22) with cmd_ready=0 -> jdo=38'h22, cmd_valid=1, overrun=1. Pulse overrun_clr -> overrun=0. Repeat with overrun_clr held in the overwrite cycle -> overrun=1.
- cmd_ready=1 in the exact cycle of a new udr_edge -> cmd_valid stays 1, jdo holds the new data, overrun stays 0.
- uir and udr edges coincident, ir_in=2'b10 with ir_q=0 -> cmd_ir=2, take_action/take_no_action bit 2 pulses. Regression at SYNC_STAGES=3, IR_W=3, DATA_W=48 -> latency 4 cycles, 8-bit pulse vectors.

Source files
------------

// File: rtl/nios2_debug_cmd_sync.sv
// Nios II JTAG debug slave, system-clock side: synchronises TCK update strobes,
// captures each completed DR scan as a command with valid/ready handshake and decodes action pulses.
module nios2_debug_cmd_sync #(
   parameter int DATA_W      = 38,
   parameter int IR_W        = 2,
   parameter int SYNC_STAGES = 2,
   parameter int ACT_BIT     = 34
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_W-1:0]    sr,
   input  logic [IR_W-1:0]      ir_in,
   input  logic                 vs_uir,
   input  logic                 vs_udr,
   output logic [DATA_W-1:0]    jdo,
   output logic                 cmd_valid,
   output logic [IR_W-1:0]      cmd_ir,
   input  logic                 cmd_ready,
   output logic [2**IR_W-1:0]   take_action,
   output logic [2**IR_W-1:0]   take_no_action,
   output logic                 ir_update,
   output logic                 overrun,
   input  logic                 overrun_clr
);

   localparam int NCH = 2**IR_W;

   logic [SYNC_STAGES-1:0] udr_sync_q, uir_sync_q;
   logic                   udr_prev_q, uir_prev_q;
   logic                   udr_edge, uir_edge;

   logic [IR_W-1:0]        ir_q, ir_d;
   logic                   ir_update_q, ir_update_d;
   logic [DATA_W-1:0]      jdo_q, jdo_d;
   logic [IR_W-1:0]        cmd_ir_q, cmd_ir_d;
   logic                   cmd_valid_q, cmd_valid_d;
   logic [NCH-1:0]         act_q, act_d;
   logic [NCH-1:0]         noact_q, noact_d;
   logic                   overrun_q, overrun_d;
   logic [IR_W-1:0]        cur_ir;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         udr_sync_q <= '0;
         uir_sync_q <= '0;
         udr_prev_q <= 1'b0;
         uir_prev_q <= 1'b0;
      end else begin
         udr_sync_q <= {udr_sync_q[SYNC_STAGES-2:0], vs_udr};
         uir_sync_q <= {uir_sync_q[SYNC_STAGES-2:0], vs_uir};
         udr_prev_q <= udr_sync_q[SYNC_STAGES-1];
         uir_prev_q <= uir_sync_q[SYNC_STAGES-1];
      end
   end

   assign udr_edge = udr_sync_q[SYNC_STAGES-1] & ~udr_prev_q;
   assign uir_edge = uir_sync_q[SYNC_STAGES-1] & ~uir_prev_q;

   // A DR update coincident with an IR update belongs to the new IR.
   assign cur_ir = uir_edge ? ir_in : ir_q;

   always_comb begin
      ir_d        = uir_edge ? ir_in : ir_q;
      ir_update_d = uir_edge;
      jdo_d       = jdo_q;
      cmd_ir_d    = cmd_ir_q;
      cmd_valid_d = cmd_valid_q;
      act_d       = '0;
      noact_d     = '0;
      overrun_d   = overrun_q;

      if (overrun_clr)
         overrun_d = 1'b0;

      if (udr_edge) begin
         jdo_d       = sr;
         cmd_ir_d    = cur_ir;
         cmd_valid_d = 1'b1;
         if (sr[ACT_BIT])
            act_d[cur_ir] = 1'b1;
         else
            noact_d[cur_ir] = 1'b1;
         if (cmd_valid_q && !cmd_ready)
            overrun_d = 1'b1;
      end else if (cmd_valid_q && cmd_ready) begin
         cmd_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ir_q        <= '0;
         ir_update_q <= 1'b0;
         jdo_q       <= '0;
         cmd_ir_q    <= '0;
         cmd_valid_q <= 1'b0;
         act_q       <= '0;
         noact_q     <= '0;
         overrun_q   <= 1'b0;
      end else begin
         ir_q        <= ir_d;
         ir_update_q <= ir_update_d;
         jdo_q       <= jdo_d;
         cmd_ir_q    <= cmd_ir_d;
         cmd_valid_q <= cmd_valid_d;
         act_q       <= act_d;
         noact_q     <= noact_d;
         overrun_q   <= overrun_d;
      end
   end

   assign jdo            = jdo_q;
   assign cmd_valid      = cmd_valid_q;
   assign cmd_ir         = cmd_ir_q;
   assign take_action    = act_q;
   assign take_no_action = noact_q;
   assign ir_update      = ir_update_q;
   assign overrun        = overrun_q;

endmodule

// File: tb/tb_nios2_debug_cmd_sync.sv
// Directed bench for nios2_debug_cmd_sync: scoreboard of expected captures plus
// handshake, overrun, coincident-edge, reset and a wider-parameter latency check.
module tb_nios2_debug_cmd_sync;

   localparam int DW = 38;
   localparam int IW = 2;

   logic          clk, reset;
   logic [DW-1:0] sr;
   logic [IW-1:0] ir_in;
   logic          vs_uir, vs_udr, cmd_ready, overrun_clr;
   logic [DW-1:0] jdo;
   logic          cmd_valid, ir_update, overrun;
   logic [IW-1:0] cmd_ir;
   logic [3:0]    take_action, take_no_action;

   logic [47:0]   sr3, jdo3;
   logic [2:0]    ir3, cmd_ir3;
   logic          uir3, udr3, cmd_valid3, ir_update3, overrun3;
   logic [7:0]    ta3, tna3;

   typedef struct packed {
      logic [37:0] data;
      logic [1:0]  ir;
      logic        act;
   } exp_t;

   exp_t          exp_q[$];
   int            tests = 0;
   int            fails = 0;
   int            n;
   logic [1:0]    ir_model;

   nios2_debug_cmd_sync u_dut (
      .clk(clk), .reset(reset), .sr(sr), .ir_in(ir_in), .vs_uir(vs_uir), .vs_udr(vs_udr),
      .jdo(jdo), .cmd_valid(cmd_valid), .cmd_ir(cmd_ir), .cmd_ready(cmd_ready),
      .take_action(take_action), .take_no_action(take_no_action), .ir_update(ir_update),
      .overrun(overrun), .overrun_clr(overrun_clr)
   );

   nios2_debug_cmd_sync #(.DATA_W(48), .IR_W(3), .SYNC_STAGES(3), .ACT_BIT(34)) u_dut3 (
      .clk(clk), .reset(reset), .sr(sr3), .ir_in(ir3), .vs_uir(uir3), .vs_udr(udr3),
      .jdo(jdo3), .cmd_valid(cmd_valid3), .cmd_ir(cmd_ir3), .cmd_ready(1'b0),
      .take_action(ta3), .take_no_action(tna3), .ir_update(ir_update3),
      .overrun(overrun3), .overrun_clr(1'b0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      tests++;
      assert (obs === expv) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Every decoded pulse must match the oldest outstanding capture.
   always @(negedge clk) begin
      if (!reset && ((take_action | take_no_action) != 4'b0)) begin
         if (exp_q.size() == 0) begin
            check("unexpected_pulse", 64'(take_action | take_no_action), 64'(0));
         end else begin
            exp_t e;
            logic [3:0] onehot;
            e = exp_q.pop_front();
            onehot = 4'b0001 << e.ir;
            check("sb_jdo", 64'(jdo), 64'(e.data));
            check("sb_cmd_ir", 64'(cmd_ir), 64'(e.ir));
            check("sb_take_action", 64'(take_action), 64'(e.act ? onehot : 4'b0));
            check("sb_take_no_action", 64'(take_no_action), 64'(e.act ? 4'b0 : onehot));
         end
      end
   end

   task automatic push_exp(input logic [37:0] d);
      exp_t e;
      e.data = d;
      e.ir   = ir_model;
      e.act  = d[34];
      exp_q.push_back(e);
   endtask

   task automatic ir_scan(input logic [1:0] v);
      ir_in  = v;
      vs_uir = 1'b1;
      n = 0;
      do begin tick(); n++; end while (!ir_update && n < 20);
      check("ir_update_latency", 64'(n), 64'(3));
      tick();
      check("ir_update_width", 64'(ir_update), 64'(0));
      vs_uir = 1'b0;
      repeat (3) tick();
      ir_model = v;
   endtask

   task automatic dr_scan(input logic [37:0] d, input int hold, input bit meas);
      push_exp(d);
      sr     = d;
      vs_udr = 1'b1;
      if (meas) begin
         n = 0;
         do begin tick(); n++; end while (((take_action | take_no_action) == 4'b0) && n < 20);
         check("udr_latency", 64'(n), 64'(3));
      end
      repeat (hold) tick();
      vs_udr = 1'b0;
      repeat (4) tick();
   endtask

   initial begin
      reset = 1'b1; sr = '0; ir_in = '0; vs_uir = 1'b0; vs_udr = 1'b0;
      cmd_ready = 1'b0; overrun_clr = 1'b0; ir_model = 2'd0;
      sr3 = '0; ir3 = '0; uir3 = 1'b0; udr3 = 1'b0;
      repeat (3) tick();
      check("rst_jdo", 64'(jdo), 64'(0));
      check("rst_cmd_valid", 64'(cmd_valid), 64'(0));
      check("rst_cmd_ir", 64'(cmd_ir), 64'(0));
      check("rst_take_action", 64'(take_action), 64'(0));
      check("rst_take_no_action", 64'(take_no_action), 64'(0));
      check("rst_ir_update", 64'(ir_update), 64'(0));
      check("rst_overrun", 64'(overrun), 64'(0));
      reset = 1'b0;
      tick();

      // Wide variant: coincident IR/DR update, three-stage synchroniser.
      sr3 = 48'h0004_0000_0001; ir3 = 3'd5; uir3 = 1'b1; udr3 = 1'b1;
      n = 0;
      do begin tick(); n++; end while (((ta3 | tna3) == 8'b0) && n < 20);
      check("w_latency", 64'(n), 64'(4));
      check("w_take_action", 64'(ta3), 64'(8'h20));
      check("w_take_no_action", 64'(tna3), 64'(0));
      check("w_jdo", 64'(jdo3), 64'(48'h0004_0000_0001));
      check("w_cmd_ir", 64'(cmd_ir3), 64'(5));
      uir3 = 1'b0; udr3 = 1'b0;
      repeat (3) tick();

      // Action command on channel 1, vs_udr held for 10 clocks.
      ir_scan(2'b01);
      dr_scan(38'h04_0000_1234, 7, 1'b1);
      check("act_cmd_valid", 64'(cmd_valid), 64'(1));
      check("act_overrun", 64'(overrun), 64'(0));
      cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
      check("act_accept", 64'(cmd_valid), 64'(0));

      // No-action command on channel 3, accepted a cycle later.
      ir_scan(2'b11);
      dr_scan(38'h00_0000_00FF, 3, 1'b1);
      check("noact_cmd_valid", 64'(cmd_valid), 64'(1));
      cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
      check("noact_accept", 64'(cmd_valid), 64'(0));
      cmd_ready = 1'b1; repeat (2) tick(); cmd_ready = 1'b0;
      check("idle_ready_valid", 64'(cmd_valid), 64'(0));
      check("idle_ready_overrun", 64'(overrun), 64'(0));

      // Overwrite without acceptance.
      dr_scan(38'h11, 3, 1'b0);
      dr_scan(38'h22, 3, 1'b0);
      check("ovr_jdo", 64'(jdo), 64'(38'h22));
      check("ovr_cmd_valid", 64'(cmd_valid), 64'(1));
      check("ovr_set", 64'(overrun), 64'(1));
      overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
      check("ovr_clear", 64'(overrun), 64'(0));

      // Clear asserted exactly in the overwrite cycle: set must win.
      push_exp(38'h33);
      sr = 38'h33; vs_udr = 1'b1;
      tick(); tick();
      overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
      check("ovr_set_wins", 64'(overrun), 64'(1));
      check("ovr_set_wins_jdo", 64'(jdo), 64'(38'h33));
      vs_udr = 1'b0;
      repeat (4) tick();
      overrun_clr = 1'b1; tick(); overrun_clr = 1'b0;
      check("ovr_clear2", 64'(overrun), 64'(0));

      // Accept in the same cycle as a new capture.
      push_exp(38'h44);
      sr = 38'h44; vs_udr = 1'b1;
      tick(); tick();
      cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
      check("acc_udr_valid", 64'(cmd_valid), 64'(1));
      check("acc_udr_overrun", 64'(overrun), 64'(0));
      check("acc_udr_jdo", 64'(jdo), 64'(38'h44));
      vs_udr = 1'b0;
      repeat (4) tick();
      cmd_ready = 1'b1; tick(); cmd_ready = 1'b0;
      check("acc_valid_clear", 64'(cmd_valid), 64'(0));
      check("acc_jdo_hold", 64'(jdo), 64'(38'h44));
      check("acc_cmd_ir_hold", 64'(cmd_ir), 64'(3));

      // Coincident IR and DR updates use the incoming IR.
      ir_scan(2'b00);
      sr = 38'h05_5555_5555; ir_in = 2'b10; ir_model = 2'b10;
      push_exp(38'h05_5555_5555);
      vs_uir = 1'b1; vs_udr = 1'b1;
      repeat (3) tick();
      check("coin_ir_update", 64'(ir_update), 64'(1));
      check("coin_cmd_ir", 64'(cmd_ir), 64'(2));
      vs_uir = 1'b0; vs_udr = 1'b0;
      repeat (4) tick();

      // Reset with a pending command and vs_udr high.
      sr = 38'h00_0000_0ABC; vs_udr = 1'b1; reset = 1'b1;
      repeat (3) tick();
      check("mrst_cmd_valid", 64'(cmd_valid), 64'(0));
      check("mrst_jdo", 64'(jdo), 64'(0));
      check("mrst_cmd_ir", 64'(cmd_ir), 64'(0));
      check("mrst_pulses", 64'(take_action | take_no_action), 64'(0));
      ir_model = 2'b00;
      push_exp(38'h00_0000_0ABC);
      reset = 1'b0;
      n = 0;
      do begin tick(); n++; end while (((take_action | take_no_action) == 4'b0) && n < 20);
      check("mrst_latency", 64'(n), 64'(3));
      check("mrst_valid", 64'(cmd_valid), 64'(1));
      vs_udr = 1'b0;
      repeat (4) tick();

      check("sb_drained", 64'(exp_q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
